proc_ctrl_mc: RTL and testbench

PROC_CTRL_MC -- requirements
Module: proc_ctrl_mc

---
 rtl/tinyrv1_pkg.sv | 67 ++++++
 rtl/proc_ctrl_mc_if.sv | 21 ++
 rtl/proc_ctrl_decode.sv | 38 +++
 rtl/proc_ctrl_mc.sv | 160 ++++++++++++++++
 tb/tb_proc_ctrl_mc.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/tinyrv1_pkg.sv
// Shared TinyRV1 control definitions: FSM states, mux encodings, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tinyrv1_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_MUL,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_J = 2'b10,
    IMM_B = 2'b11
  } imm_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_MUL = 2'd3
  } wb_sel_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  // One-hot operation class; all-zero means the instruction is not legal.
  typedef struct packed {
    logic add;
    logic mul;
    logic addi;
    logic lw;
    logic sw;
    logic jal;
    logic jr;
    logic bne;
  } op_t;

endpackage

// File: rtl/proc_ctrl_mc_if.sv
// Memory request/response handshake between the controller and memory.
// Latency: n/a (wires only).
// Backpressure: request held by master until mem_req_rdy; response is a single-cycle valid.
// Ports: mem_req_val/mem_req_wr/addr_sel from controller; mem_req_rdy/mem_resp_val from memory.
interface proc_ctrl_mc_if;
  logic mem_req_val;
  logic mem_req_wr;
  logic addr_sel;
  logic mem_req_rdy;
  logic mem_resp_val;

  modport master (
    output mem_req_val, mem_req_wr, addr_sel,
    input  mem_req_rdy, mem_resp_val
  );

  modport slave (
    input  mem_req_val, mem_req_wr, addr_sel,
    output mem_req_rdy, mem_resp_val
  );
endinterface

// File: rtl/proc_ctrl_decode.sv
// Instruction classifier: ir -> one-hot op class plus illegal flag.
// Latency: combinational.
// Backpressure: none.
// Ports: ir in; op (op_t) out; illegal out.
module proc_ctrl_decode
  import tinyrv1_pkg::*;
(
  input  logic [31:0] ir,
  output op_t         op,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  // Register/immediate fields do not influence control decode.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  always_comb begin
    op      = '0;
    op.add  = (opc == OPC_OP)     && (f3 == F3_ADD)  && (f7 == F7_ADD);
    op.mul  = (opc == OPC_OP)     && (f3 == F3_ADD)  && (f7 == F7_MUL);
    op.addi = (opc == OPC_OP_IMM) && (f3 == F3_ADD);
    op.lw   = (opc == OPC_LOAD)   && (f3 == F3_WORD);
    op.sw   = (opc == OPC_STORE)  && (f3 == F3_WORD);
    op.jal  = (opc == OPC_JAL);
    op.jr   = (opc == OPC_JALR)   && (f3 == F3_JALR);
    op.bne  = (opc == OPC_BRANCH) && (f3 == F3_BNE);
    illegal = (op == '0);
  end

endmodule

// File: rtl/proc_ctrl_mc.sv
// Multi-cycle TinyRV1 control unit: fetch/decode/exec FSM with 8-cycle iterative multiply.
// Latency: ALU/jump/branch 4 cycles, LW/SW 6 cycles, MUL decode+exec plus 8 MUL cycles (zero-wait memory).
// Backpressure: mem_req_val held with stable mem_req_wr/addr_sel until mem_req_rdy; waits on mem_resp_val.
// Ports: clk, rst (async, active-high); ir, br_eq in; mem (master modport);
//        ir_en, pc_en, pc_sel, imm_type, op2_sel, mul_en, rf_wen, wb_sel, halted out.
module proc_ctrl_mc
  import tinyrv1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ir,
  input  logic                  br_eq,
  proc_ctrl_mc_if.master        mem,
  output logic                  ir_en,
  output logic                  pc_en,
  output logic [1:0]            pc_sel,
  output logic [1:0]            imm_type,
  output logic                  op2_sel,
  output logic                  mul_en,
  output logic                  rf_wen,
  output logic [1:0]            wb_sel,
  output logic                  halted
);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  op_t        op;
  logic       illegal;
  logic       req_val, req_wr, req_addr_sel;

  // ir is held externally after ir_en, so decode stays valid through EXEC and MEM states.
  proc_ctrl_decode u_decode (
    .ir      (ir),
    .op      (op),
    .illegal (illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_val      = 1'b0;
    req_wr       = 1'b0;
    req_addr_sel = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_PLUS4;
    imm_type     = IMM_I;
    op2_sel      = 1'b0;
    mul_en       = 1'b0;
    rf_wen       = 1'b0;
    wb_sel       = WB_ALU;
    halted       = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH_REQ;

      ST_FETCH_REQ: begin
        req_val = 1'b1;
        if (mem.mem_req_rdy) state_d = ST_FETCH_WAIT;
      end

      ST_FETCH_WAIT: begin
        if (mem.mem_resp_val) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: state_d = illegal ? ST_HALT : ST_EXEC;

      ST_EXEC: begin
        state_d = ST_FETCH_REQ;
        if (op.add || op.addi) begin
          rf_wen   = 1'b1;
          wb_sel   = WB_ALU;
          op2_sel  = op.addi;
          imm_type = IMM_I;
          pc_en    = 1'b1;
          pc_sel   = PC_PLUS4;
        end else if (op.jal) begin
          imm_type = IMM_J;
          rf_wen   = 1'b1;
          wb_sel   = WB_PC4;
          pc_en    = 1'b1;
          pc_sel   = PC_JUMP;
        end else if (op.jr) begin
          pc_en  = 1'b1;
          pc_sel = PC_REG;
        end else if (op.bne) begin
          imm_type = IMM_B;
          pc_en    = 1'b1;
          pc_sel   = br_eq ? PC_PLUS4 : PC_BRANCH;
        end else if (op.lw || op.sw) begin
          op2_sel  = 1'b1;
          imm_type = op.sw ? IMM_S : IMM_I;
          state_d  = ST_MEM_REQ;
        end else if (op.mul) begin
          cnt_d   = 3'd0;
          state_d = ST_MUL;
        end else begin
          // ir changed after decode; stop rather than execute garbage.
          state_d = ST_HALT;
        end
      end

      ST_MUL: begin
        mul_en = 1'b1;
        if (cnt_q == 3'd7) begin
          rf_wen  = 1'b1;
          wb_sel  = WB_MUL;
          pc_en   = 1'b1;
          pc_sel  = PC_PLUS4;
          cnt_d   = 3'd0;
          state_d = ST_FETCH_REQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_MEM_REQ: begin
        req_val      = 1'b1;
        req_addr_sel = 1'b1;
        req_wr       = op.sw;
        imm_type     = op.sw ? IMM_S : IMM_I;
        if (mem.mem_req_rdy) state_d = ST_MEM_WAIT;
      end

      ST_MEM_WAIT: begin
        if (mem.mem_resp_val) begin
          if (op.lw) begin
            rf_wen = 1'b1;
            wb_sel = WB_MEM;
          end
          pc_en   = 1'b1;
          pc_sel  = PC_PLUS4;
          state_d = ST_FETCH_REQ;
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem.mem_req_val = req_val;
  assign mem.mem_req_wr  = req_wr;
  assign mem.addr_sel    = req_addr_sel;

endmodule

// File: tb/tb_proc_ctrl_mc.sv
// Directed bench for proc_ctrl_mc: per-cycle output vectors against hand-computed values.
// Latency: n/a.
// Backpressure: memory handshake driven directly from the stimulus.
module tb_proc_ctrl_mc;

  logic        clk;
  logic        rst;
  logic [31:0] ir;
  logic        br_eq;
  logic        ir_en, pc_en, op2_sel, mul_en, rf_wen, halted;
  logic [1:0]  pc_sel, imm_type, wb_sel;

  int n_checks = 0;
  int n_fail   = 0;

  proc_ctrl_mc_if m();

  proc_ctrl_mc dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .br_eq    (br_eq),
    .mem      (m),
    .ir_en    (ir_en),
    .pc_en    (pc_en),
    .pc_sel   (pc_sel),
    .imm_type (imm_type),
    .op2_sel  (op2_sel),
    .mul_en   (mul_en),
    .rf_wen   (rf_wen),
    .wb_sel   (wb_sel),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flattened view of every controller output, MSB first:
  // req_val, wr, addr_sel, ir_en, pc_en, pc_sel[2], imm[2], op2, mul_en, rf_wen, wb_sel[2], halted
  logic [14:0] obs;
  assign obs = {m.mem_req_val, m.mem_req_wr, m.addr_sel, ir_en, pc_en, pc_sel,
                imm_type, op2_sel, mul_en, rf_wen, wb_sel, halted};

  function automatic logic [14:0] o(input logic rv, input logic wr, input logic as,
                                    input logic ire, input logic pce, input logic [1:0] ps,
                                    input logic [1:0] imm, input logic op2, input logic mul,
                                    input logic rf, input logic [1:0] wb, input logic hl);
    return {rv, wr, as, ire, pce, ps, imm, op2, mul, rf, wb, hl};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, check outputs, move to the next falling edge.
  task automatic cyc(input string tag, input logic rdy, input logic resp,
                     input logic beq, input logic [14:0] exp);
    m.mem_req_rdy  = rdy;
    m.mem_resp_val = resp;
    br_eq          = beq;
    #1;
    check(tag, {17'd0, obs}, {17'd0, exp});
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle; returns at a falling edge with the DUT in FETCH_REQ.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_now"}, {17'd0, obs}, 32'd0);
    @(negedge clk);
    m.mem_req_rdy  = 1'b1;
    m.mem_resp_val = 1'b1;
    #1;
    check({tag, "_rst_held"}, {17'd0, obs}, 32'd0);
    rst = 1'b0;
    #1;
    check({tag, "_idle"}, {17'd0, obs}, 32'd0);
    @(negedge clk);
  endtask

  logic [14:0] e_fr, e_fw, z;

  // Fetch with zero-wait memory, then the decode cycle; rdy/resp raised in DECODE must be ignored.
  task automatic fetch_dec(input string tag);
    cyc({tag, "_fr"},  1'b1, 1'b0, 1'b0, e_fr);
    cyc({tag, "_fw"},  1'b0, 1'b1, 1'b0, e_fw);
    cyc({tag, "_dec"}, 1'b1, 1'b1, 1'b0, z);
  endtask

  initial begin
    z    = '0;
    e_fr = o(1,0,0, 0,0,2'd0, 2'd0,0,0,0,2'd0,0);
    e_fw = o(0,0,0, 1,0,2'd0, 2'd0,0,0,0,2'd0,0);

    rst = 1'b1;
    ir = 32'h0;
    br_eq = 1'b0;
    m.mem_req_rdy = 1'b0;
    m.mem_resp_val = 1'b0;
    @(negedge clk);
    check("reset_outs", {17'd0, obs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_outs", {17'd0, obs}, 32'd0);
    @(negedge clk);

    // ADDI x1,x0,5: writeback in the 4th cycle from fetch start.
    ir = 32'h00500093;
    fetch_dec("addi");
    cyc("addi_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,1,2'd0, 2'd0,1,0,1,2'd0,0));

    // ADD x3,x1,x2
    ir = 32'h002081B3;
    fetch_dec("add");
    cyc("add_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,1,2'd0, 2'd0,0,0,1,2'd0,0));

    // BNE x1,x2,+8 taken, then not taken.
    ir = 32'h00209463;
    fetch_dec("bne0");
    cyc("bne0_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,1,2'd1, 2'd3,0,0,0,2'd0,0));
    fetch_dec("bne1");
    cyc("bne1_exec", 1'b0, 1'b0, 1'b1, o(0,0,0, 0,1,2'd0, 2'd3,0,0,0,2'd0,0));

    // JAL x1,+16
    ir = 32'h010000EF;
    fetch_dec("jal");
    cyc("jal_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,1,2'd2, 2'd2,0,0,1,2'd2,0));

    // JR x1
    ir = 32'h00008067;
    fetch_dec("jr");
    cyc("jr_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,1,2'd3, 2'd0,0,0,0,2'd0,0));

    // LW x2,0(x1): fetch stalls one cycle, memory stalls 3 cycles, response one cycle late.
    ir = 32'h0000A103;
    cyc("lw_fr_stall", 1'b0, 1'b1, 1'b0, e_fr);
    fetch_dec("lw");
    cyc("lw_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,0,2'd0, 2'd0,1,0,0,2'd0,0));
    for (int i = 0; i < 3; i++)
      cyc("lw_memreq_stall", 1'b0, 1'b1, 1'b0, o(1,0,1, 0,0,2'd0, 2'd0,0,0,0,2'd0,0));
    cyc("lw_memreq_acc", 1'b1, 1'b0, 1'b0, o(1,0,1, 0,0,2'd0, 2'd0,0,0,0,2'd0,0));
    cyc("lw_memwait", 1'b1, 1'b0, 1'b0, z);
    cyc("lw_resp", 1'b0, 1'b1, 1'b0, o(0,0,0, 0,1,2'd0, 2'd0,0,0,1,2'd1,0));

    // MUL x3,x1,x2: eight mul_en cycles, writeback only on the last.
    ir = 32'h022081B3;
    fetch_dec("mul");
    cyc("mul_exec", 1'b0, 1'b0, 1'b0, z);
    for (int i = 0; i < 7; i++)
      cyc("mul_busy", 1'b1, 1'b1, 1'b0, o(0,0,0, 0,0,2'd0, 2'd0,0,1,0,2'd0,0));
    cyc("mul_last", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,1,2'd0, 2'd0,0,1,1,2'd3,0));
    cyc("mul_refetch", 1'b0, 1'b0, 1'b0, e_fr);
    cyc("mul_refetch_hold", 1'b1, 1'b0, 1'b0, e_fr);
    cyc("mul2_fw", 1'b0, 1'b1, 1'b0, e_fw);
    cyc("mul2_dec", 1'b0, 1'b0, 1'b0, z);
    cyc("mul2_exec", 1'b0, 1'b0, 1'b0, z);

    // Reset part-way through MUL.
    cyc("mul2_busy", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,0,2'd0, 2'd0,0,1,0,2'd0,0));
    cyc("mul2_busy", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,0,2'd0, 2'd0,0,1,0,2'd0,0));
    #3;
    do_reset("mul");

    // SW x2,0(x1): reset lands between edges while the response is present in MEM_WAIT.
    ir = 32'h0020A023;
    fetch_dec("sw");
    cyc("sw_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,0,2'd0, 2'd1,1,0,0,2'd0,0));
    cyc("sw_memreq", 1'b1, 1'b0, 1'b0, o(1,1,1, 0,0,2'd0, 2'd1,0,0,0,2'd0,0));
    m.mem_req_rdy  = 1'b0;
    m.mem_resp_val = 1'b1;
    #1;
    check("sw_resp", {17'd0, obs}, {17'd0, o(0,0,0, 0,1,2'd0, 2'd0,0,0,0,2'd0,0)});
    #2;
    do_reset("sw");
    cyc("sw_refetch", 1'b0, 1'b0, 1'b0, e_fr);

    // Illegal instruction: absorbing HALT, no memory requests even with rdy/resp high.
    ir = 32'hFFFFFFFF;
    cyc("ill_fr", 1'b1, 1'b0, 1'b0, e_fr);
    cyc("ill_fw", 1'b0, 1'b1, 1'b0, e_fw);
    cyc("ill_dec", 1'b1, 1'b1, 1'b0, z);
    for (int i = 0; i < 6; i++)
      cyc("halt", 1'b1, 1'b1, 1'b1, o(0,0,0, 0,0,2'd0, 2'd0,0,0,0,2'd0,1));
    #2;
    do_reset("halt");
    ir = 32'h00500093;
    cyc("halt_refetch", 1'b1, 1'b0, 1'b0, e_fr);
    cyc("post_fw", 1'b0, 1'b1, 1'b0, e_fw);
    cyc("post_dec", 1'b0, 1'b0, 1'b0, z);
    cyc("post_exec", 1'b0, 1'b0, 1'b0, o(0,0,0, 0,1,2'd0, 2'd0,1,0,1,2'd0,0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
